// File: rtl/srff_ctrl.sv
// rtl/srff_ctrl.sv - command-side s/r pulse driver with readback, retry and status response
module srff_ctrl #(
  parameter int PULSE_W   = 1,
  parameter int SETTLE    = 2,
  parameter int MAX_RETRY = 2,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [1:0]       req_cmd,
  output logic             req_ready,
  output logic             s,
  output logic             r,
  input  logic             q_fb,
  input  logic             qbar_fb,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_ok,
  output logic             rsp_q,
  output logic [1:0]       rsp_tries,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int TMR_MAX = (PULSE_W > SETTLE) ? PULSE_W : SETTLE;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int TRY_W   = $clog2(MAX_RETRY + 2) + 1;

  localparam logic [1:0] CMD_HOLD  = 2'b00;
  localparam logic [1:0] CMD_CLEAR = 2'b01;
  localparam logic [1:0] CMD_SET   = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK,
    ST_RSP
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [TRY_W-1:0]   tries_q, tries_d;
  logic               exp_q, exp_d;
  logic               hold_q, hold_d;
  logic               s_q, s_d;
  logic               r_q, r_d;
  logic               req_ready_q, req_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_ok_q, rsp_ok_d;
  logic               rsp_q_q, rsp_q_d;
  logic [1:0]         rsp_tries_q, rsp_tries_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic               match;
  logic [1:0]         tries_sat;

  // Attempt count as reported: the 2-bit field sticks at 3.
  always_comb begin
    tries_sat = (tries_q > TRY_W'(3)) ? 2'd3 : tries_q[1:0];
  end

  // Next-state and registered-output computation; s/r derive from the next state so they
  // can never both be high and fall together with the DRIVE window.
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    tries_d     = tries_q;
    exp_d       = exp_q;
    hold_d      = hold_q;
    rsp_valid_d = rsp_valid_q;
    rsp_ok_d    = rsp_ok_q;
    rsp_q_d     = rsp_q_q;
    rsp_tries_d = rsp_tries_q;
    err_cnt_d   = err_cnt_q;
    match       = (q_fb == exp_q) && (qbar_fb == ~exp_q);

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          hold_d  = (req_cmd == CMD_HOLD);
          tries_d = '0;
          case (req_cmd)
            CMD_SET:   exp_d = 1'b1;
            CMD_CLEAR: exp_d = 1'b0;
            CMD_HOLD:  exp_d = q_fb;
            default:   exp_d = ~q_fb;
          endcase
          if (req_cmd == CMD_HOLD) begin
            state_d = ST_SETTLE;
            tmr_d   = TMR_W'(SETTLE - 1);
          end else begin
            state_d = ST_DRIVE;
            tmr_d   = TMR_W'(PULSE_W - 1);
            tries_d = TRY_W'(1);
          end
        end
      end
      ST_DRIVE: begin
        if (tmr_q == '0) begin
          state_d = ST_SETTLE;
          tmr_d   = TMR_W'(SETTLE - 1);
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_SETTLE: begin
        if (tmr_q == '0) begin
          state_d = ST_CHECK;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_CHECK: begin
        if (match) begin
          state_d     = ST_RSP;
          rsp_valid_d = 1'b1;
          rsp_ok_d    = 1'b1;
          rsp_q_d     = q_fb;
          rsp_tries_d = tries_sat;
        end else if (!hold_q && (tries_q <= TRY_W'(MAX_RETRY))) begin
          // Retry drives toward the value latched at accept, not a fresh readback.
          state_d = ST_DRIVE;
          tmr_d   = TMR_W'(PULSE_W - 1);
          tries_d = tries_q + TRY_W'(1);
        end else begin
          state_d     = ST_RSP;
          rsp_valid_d = 1'b1;
          rsp_ok_d    = 1'b0;
          rsp_q_d     = q_fb;
          rsp_tries_d = tries_sat;
          if (err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    s_d         = (state_d == ST_DRIVE) &&  exp_d;
    r_d         = (state_d == ST_DRIVE) && !exp_d;
    req_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers; reset clears s/r immediately without waiting for a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      tmr_q       <= '0;
      tries_q     <= '0;
      exp_q       <= 1'b0;
      hold_q      <= 1'b0;
      s_q         <= 1'b0;
      r_q         <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_ok_q    <= 1'b0;
      rsp_q_q     <= 1'b0;
      rsp_tries_q <= 2'd0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      tries_q     <= tries_d;
      exp_q       <= exp_d;
      hold_q      <= hold_d;
      s_q         <= s_d;
      r_q         <= r_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_ok_q    <= rsp_ok_d;
      rsp_q_q     <= rsp_q_d;
      rsp_tries_q <= rsp_tries_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign req_ready = req_ready_q;
  assign s         = s_q;
  assign r         = r_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_ok    = rsp_ok_q;
  assign rsp_q     = rsp_q_q;
  assign rsp_tries = rsp_tries_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_srff_ctrl.sv
// tb/tb_srff_ctrl.sv - directed self-checking bench for srff_ctrl
module tb_srff_ctrl;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic [1:0] req_cmd;
  logic       req_ready;
  logic       s;
  logic       r;
  logic       q_fb;
  logic       qbar_fb;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_ok;
  logic       rsp_q;
  logic [1:0] rsp_tries;
  logic [7:0] err_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic q_m    = 1'b0;
  logic qbar_m = 1'b1;
  logic stuck0 = 1'b0;
  logic force11 = 1'b0;

  srff_ctrl #(.PULSE_W(1), .SETTLE(2), .MAX_RETRY(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_cmd(req_cmd), .req_ready(req_ready),
    .s(s), .r(r), .q_fb(q_fb), .qbar_fb(qbar_fb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_ok(rsp_ok), .rsp_q(rsp_q), .rsp_tries(rsp_tries), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SR flop model: q follows s/r at the edge, qbar lags q by one cycle.
  always @(posedge clk) begin
    if (stuck0)  q_m <= 1'b0;
    else if (s)  q_m <= 1'b1;
    else if (r)  q_m <= 1'b0;
    qbar_m <= ~q_m;
  end

  assign q_fb    = force11 ? 1'b1 : (stuck0 ? 1'b0 : q_m);
  assign qbar_fb = force11 ? 1'b1 : (stuck0 ? 1'b1 : qbar_m);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) chk("s_and_r", {31'd0, s & r}, 32'd0);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one request, then wait (bounded) for rsp_valid counting s/r cycles.
  task automatic do_req(input logic [1:0] cmd, output int lat, output int s_cnt, output int r_cnt);
    req_valid = 1'b1;
    req_cmd   = cmd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_cmd   = 2'b11;
    lat = 0; s_cnt = 0; r_cnt = 0;
    while (!rsp_valid && lat < 50) begin
      s_cnt += int'(s);
      r_cnt += int'(r);
      tick();
      lat++;
    end
  endtask

  task automatic finish_rsp;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("post_rsp_ready", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic check_rsp(input string tag, input int lat, input int s_cnt, input int r_cnt,
                           input int e_lat, input int e_s, input int e_r,
                           input logic e_ok, input logic e_q, input logic [1:0] e_tries);
    chk({tag, "_lat"},   lat,   e_lat);
    chk({tag, "_s"},     s_cnt, e_s);
    chk({tag, "_r"},     r_cnt, e_r);
    chk({tag, "_ok"},    {31'd0, rsp_ok}, {31'd0, e_ok});
    chk({tag, "_q"},     {31'd0, rsp_q},  {31'd0, e_q});
    chk({tag, "_tries"}, {30'd0, rsp_tries}, {30'd0, e_tries});
  endtask

  initial begin
    int lat, sc, rc;
    rst       = 1'b0;
    req_valid = 1'b0;
    req_cmd   = 2'b00;
    rsp_ready = 1'b0;
    tick(); tick();
    chk("rst_s",         {31'd0, s},         32'd0);
    chk("rst_r",         {31'd0, r},         32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_ok",    {31'd0, rsp_ok},    32'd0);
    chk("rst_rsp_q",     {31'd0, rsp_q},     32'd0);
    chk("rst_rsp_tries", {30'd0, rsp_tries}, 32'd0);
    chk("rst_err_cnt",   {24'd0, err_cnt},   32'd0);
    rst = 1'b1;
    tick();
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);

    do_req(2'b10, lat, sc, rc);
    check_rsp("set", lat, sc, rc, 4, 1, 0, 1'b1, 1'b1, 2'd1);
    finish_rsp();
    do_req(2'b01, lat, sc, rc);
    check_rsp("clear", lat, sc, rc, 4, 0, 1, 1'b1, 1'b0, 2'd1);
    finish_rsp();
    do_req(2'b11, lat, sc, rc);
    check_rsp("tog1", lat, sc, rc, 4, 1, 0, 1'b1, 1'b1, 2'd1);
    finish_rsp();
    do_req(2'b11, lat, sc, rc);
    check_rsp("tog2", lat, sc, rc, 4, 0, 1, 1'b1, 1'b0, 2'd1);
    finish_rsp();
    chk("err_after_ok", {24'd0, err_cnt}, 32'd0);

    stuck0 = 1'b1;
    do_req(2'b10, lat, sc, rc);
    check_rsp("stuck", lat, sc, rc, 12, 3, 0, 1'b0, 1'b0, 2'd3);
    chk("stuck_err", {24'd0, err_cnt}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall_fields", {28'd0, rsp_ok, rsp_q, rsp_tries}, {28'd0, 1'b0, 1'b0, 2'd3});
      chk("stall_ready", {31'd0, req_ready}, 32'd0);
      chk("stall_sr", {30'd0, s, r}, 32'd0);
    end
    finish_rsp();
    stuck0 = 1'b0;

    req_valid = 1'b1;
    req_cmd   = 2'b10;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("mid_drive_s", {31'd0, s}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_s",         {31'd0, s},         32'd0);
    chk("async_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("async_err_cnt",   {24'd0, err_cnt},   32'd0);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("rel_req_ready", {31'd0, req_ready}, 32'd1);
    do_req(2'b10, lat, sc, rc);
    check_rsp("set2", lat, sc, rc, 4, 1, 0, 1'b1, 1'b1, 2'd1);
    finish_rsp();

    force11 = 1'b1;
    do_req(2'b00, lat, sc, rc);
    check_rsp("hold_bad", lat, sc, rc, 3, 0, 0, 1'b0, 1'b1, 2'd0);
    chk("hold_err", {24'd0, err_cnt}, 32'd1);
    finish_rsp();
    for (int i = 2; i <= 258; i++) begin
      do_req(2'b00, lat, sc, rc);
      if (lat >= 50) chk("sat_timeout", lat, 32'd3);
      finish_rsp();
      if (i == 254) chk("err_254", {24'd0, err_cnt}, 32'd254);
      if (i == 255) chk("err_255", {24'd0, err_cnt}, 32'd255);
    end
    chk("err_sat", {24'd0, err_cnt}, 32'd255);
    force11 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
